// File: rtl/q_timing_queue_if.sv
// q_timing_queue_if
// Purpose : groups the two handshakes of the timing-point buffer.
//           The op side carries decoded quantum ops into the buffer.
//           The issue side carries released ops out to the pulse interface.
// Signals : op_valid/op_data (into the buffer), op_ready (out of the buffer),
//           issue_valid/issue_data/issue_ts (out of the buffer).
// Modports: master = decoder/pulse-interface side, slave = q_timing_queue.
interface q_timing_queue_if #(
   parameter int DATA_W = 32,
   parameter int TS_W   = 32
);
   logic              op_valid;
   logic [DATA_W-1:0] op_data;
   logic              op_ready;
   logic              issue_valid;
   logic [DATA_W-1:0] issue_data;
   logic [TS_W-1:0]   issue_ts;

   modport master (
      output op_valid, op_data,
      input  op_ready, issue_valid, issue_data, issue_ts
   );

   modport slave (
      input  op_valid, op_data,
      output op_ready, issue_valid, issue_data, issue_ts
   );
endinterface

// File: rtl/q_timing_queue.sv
// q_timing_queue
// Purpose : timing-point buffer behind the instruction decoder. QWAIT/QWAITR
//           intervals accumulate into a saturating timeline timestamp; each
//           decoded op is tagged with the current timestamp and queued. The
//           head op is released once a free-running run timer reaches its
//           timestamp (at most one release per cycle).
// Ports   : clk, reset_n (async, active low)
//           q_time_write, q_time_sel, wait_imm, wait_reg : timeline advance
//           bus (q_timing_queue_if.slave) : op push and issue handshakes
//           run   : timer enable, also gates issue
//           flush : synchronous clear of FIFO, timeline and timer
//           timer, full, empty : status
//           late_err, ovf_err  : sticky error flags, cleared only by reset_n
// Option  : define Q_LATE_DROP_EN to discard late head entries instead of
//           issuing them.
module q_timing_queue #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 20,
   parameter int TS_W   = 32,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              q_time_write,
   input  logic              q_time_sel,
   input  logic [IMM_W-1:0]  wait_imm,
   input  logic [TS_W-1:0]   wait_reg,
   q_timing_queue_if.slave   bus,
   input  logic              run,
   input  logic              flush,
   output logic [TS_W-1:0]   timer,
   output logic              full,
   output logic              empty,
   output logic              late_err,
   output logic              ovf_err
);
   localparam int                PTR_W   = $clog2(DEPTH);
   localparam int                CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
   localparam logic [TS_W-1:0]   TS_ONE  = TS_W'(1);
   localparam logic [TS_W-1:0]   TS_MAX  = {TS_W{1'b1}};

   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic [TS_W-1:0]   mem_ts_q   [DEPTH];

   logic [TS_W-1:0]   tl_ts_q, tl_ts_d;
   logic [TS_W-1:0]   timer_q, timer_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              issue_valid_q, issue_valid_d;
   logic [DATA_W-1:0] issue_data_q, issue_data_d;
   logic [TS_W-1:0]   issue_ts_q, issue_ts_d;
   logic              late_err_q, late_err_d;
   logic              ovf_err_q, ovf_err_d;

   logic [TS_W-1:0]   interval_s;
   logic [TS_W-1:0]   sum_s;
   logic              carry_s;
   logic [DATA_W-1:0] head_data_s;
   logic [TS_W-1:0]   head_ts_s;
   logic              full_s, empty_s;
   logic              push_s, drop_s, pop_s, late_s, fire_s;

   // Datapath decode: interval select, saturating sum, FIFO head and handshake qualifiers.
   always_comb begin
      interval_s       = q_time_sel ? wait_reg : TS_W'(wait_imm);
      {carry_s, sum_s} = {1'b0, tl_ts_q} + {1'b0, interval_s};
      head_data_s      = mem_data_q[rd_ptr_q];
      head_ts_s        = mem_ts_q[rd_ptr_q];
      full_s           = (count_q == DEPTH_C);
      empty_s          = (count_q == {CNT_W{1'b0}});
      // Push is judged against the registered count, so a full FIFO rejects
      // the op even if the head pops in the same cycle.
      push_s           = bus.op_valid && !full_s && !flush;
      drop_s           = bus.op_valid && full_s && !flush;
      // Uses the pre-increment timer value.
      pop_s            = run && !empty_s && (head_ts_s <= timer_q) && !flush;
      late_s           = pop_s && (head_ts_s < timer_q);
`ifdef Q_LATE_DROP_EN
      fire_s           = pop_s && !late_s;
`else
      fire_s           = pop_s;
`endif
   end

   // Next-state logic; flush overrides everything except the sticky flags.
   always_comb begin
      tl_ts_d       = tl_ts_q;
      timer_d       = timer_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      issue_valid_d = 1'b0;
      issue_data_d  = issue_data_q;
      issue_ts_d    = issue_ts_q;
      late_err_d    = late_err_q | late_s;
      ovf_err_d     = ovf_err_q | drop_s | (q_time_write & carry_s & !flush);
      if (flush) begin
         tl_ts_d  = {TS_W{1'b0}};
         timer_d  = {TS_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (q_time_write) begin
            tl_ts_d = carry_s ? TS_MAX : sum_s;
         end else begin
            tl_ts_d = tl_ts_q;
         end
         timer_d = run ? (timer_q + TS_ONE) : {TS_W{1'b0}};
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (fire_s) begin
            issue_valid_d = 1'b1;
            issue_data_d  = head_data_s;
            issue_ts_d    = head_ts_s;
         end else begin
            issue_valid_d = 1'b0;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tl_ts_q       <= {TS_W{1'b0}};
         timer_q       <= {TS_W{1'b0}};
         wr_ptr_q      <= {PTR_W{1'b0}};
         rd_ptr_q      <= {PTR_W{1'b0}};
         count_q       <= {CNT_W{1'b0}};
         issue_valid_q <= 1'b0;
         issue_data_q  <= {DATA_W{1'b0}};
         issue_ts_q    <= {TS_W{1'b0}};
         late_err_q    <= 1'b0;
         ovf_err_q     <= 1'b0;
      end else begin
         tl_ts_q       <= tl_ts_d;
         timer_q       <= timer_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         issue_valid_q <= issue_valid_d;
         issue_data_q  <= issue_data_d;
         issue_ts_q    <= issue_ts_d;
         late_err_q    <= late_err_d;
         ovf_err_q     <= ovf_err_d;
      end
   end

   // FIFO storage; contents need no reset because the count gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_data_q[wr_ptr_q] <= bus.op_data;
         mem_ts_q[wr_ptr_q]   <= tl_ts_q;
      end
   end

   assign bus.op_ready    = !full_s;
   assign bus.issue_valid = issue_valid_q;
   assign bus.issue_data  = issue_data_q;
   assign bus.issue_ts    = issue_ts_q;
   assign timer           = timer_q;
   assign full            = full_s;
   assign empty           = empty_s;
   assign late_err        = late_err_q;
   assign ovf_err         = ovf_err_q;
endmodule

// File: tb/tb_q_timing_queue.sv
// Testbench for q_timing_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model through an issue scoreboard.
module tb_q_timing_queue;
   localparam int DATA_W = 32;
   localparam int IMM_W  = 20;
   localparam int TS_W   = 32;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              q_time_write = 1'b0;
   logic              q_time_sel = 1'b0;
   logic [IMM_W-1:0]  wait_imm = '0;
   logic [TS_W-1:0]   wait_reg = '0;
   logic              run = 1'b0;
   logic              flush = 1'b0;
   logic [TS_W-1:0]   timer;
   logic              full, empty, late_err, ovf_err;

   q_timing_queue_if #(.DATA_W(DATA_W), .TS_W(TS_W)) bus ();

   q_timing_queue #(.DATA_W(DATA_W), .IMM_W(IMM_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .q_time_write (q_time_write),
      .q_time_sel   (q_time_sel),
      .wait_imm     (wait_imm),
      .wait_reg     (wait_reg),
      .bus          (bus),
      .run          (run),
      .flush        (flush),
      .timer        (timer),
      .full         (full),
      .empty        (empty),
      .late_err     (late_err),
      .ovf_err      (ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] data; logic [31:0] ts; } entry_t;
   typedef struct { logic [31:0] data; logic [31:0] ts; int cyc; } exp_t;

   // Reference model state (state after the most recent clock edge).
   entry_t          m_q[$];
   exp_t            exp_q[$];
   longint unsigned m_tl = 0;
   longint unsigned m_timer = 0;
   bit              m_late = 0;
   bit              m_ovf = 0;
   logic [31:0]     m_last_data = '0;
   logic [31:0]     m_last_ts = '0;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_status();
      chk("timer", 64'(timer), m_timer);
      chk("empty", 64'(empty), 64'(m_q.size() == 0));
      chk("full", 64'(full), 64'(m_q.size() == DEPTH));
      chk("op_ready", 64'(bus.op_ready), 64'(m_q.size() != DEPTH));
      chk("late_err", 64'(late_err), 64'(m_late));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      chk("issue_data_hold", 64'(bus.issue_data), 64'(m_last_data));
      chk("issue_ts_hold", 64'(bus.issue_ts), 64'(m_last_ts));
   endtask

   // Predict the effect of the coming clock edge from the inputs just driven.
   task automatic model_step();
      longint unsigned iv, sum;
      bit              was_full, issues;
      entry_t          h;
      exp_t            e;
      if (flush) begin
         m_q.delete();
         m_tl = 0;
         m_timer = 0;
         return;
      end
      was_full = (m_q.size() == DEPTH);
      if (run && m_q.size() > 0 && longint'(m_q[0].ts) <= m_timer) begin
         h = m_q.pop_front();
         issues = 1;
         if (longint'(h.ts) < m_timer) begin
            m_late = 1;
`ifdef Q_LATE_DROP_EN
            issues = 0;
`endif
         end
         if (issues) begin
            e.data = h.data;
            e.ts   = h.ts;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
            m_last_data = h.data;
            m_last_ts   = h.ts;
         end
      end
      if (bus.op_valid) begin
         if (was_full) m_ovf = 1;
         else begin
            h.data = bus.op_data;
            h.ts   = m_tl[31:0];
            m_q.push_back(h);
         end
      end
      if (q_time_write) begin
         iv  = q_time_sel ? longint'(wait_reg) : longint'(wait_imm);
         sum = m_tl + iv;
         if (sum > 64'hFFFF_FFFF) begin
            m_tl  = 64'hFFFF_FFFF;
            m_ovf = 1;
         end else m_tl = sum;
      end
      m_timer = run ? ((m_timer + 1) & 64'hFFFF_FFFF) : 0;
   endtask

   task automatic tick(input bit ov, input logic [31:0] od, input bit tw, input bit sel,
                       input int wi, input logic [31:0] wr, input bit rn, input bit fl);
      @(negedge clk);
      check_status();
      bus.op_valid = ov;
      bus.op_data  = od;
      q_time_write = tw;
      q_time_sel   = sel;
      wait_imm     = IMM_W'(wi);
      wait_reg     = wr;
      run          = rn;
      flush        = fl;
      model_step();
   endtask

   task automatic idle(input int n, input bit rn);
      for (int i = 0; i < n; i++) tick(0, 32'h0, 0, 0, 0, 32'h0, rn, 0);
   endtask

   task automatic zero_inputs();
      bus.op_valid = 1'b0;
      bus.op_data  = '0;
      q_time_write = 1'b0;
      q_time_sel   = 1'b0;
      wait_imm     = '0;
      wait_reg     = '0;
      run          = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic check_reset_values();
      chk("rst_issue_valid", 64'(bus.issue_valid), 64'h0);
      chk("rst_issue_data", 64'(bus.issue_data), 64'h0);
      chk("rst_issue_ts", 64'(bus.issue_ts), 64'h0);
      chk("rst_timer", 64'(timer), 64'h0);
      chk("rst_empty", 64'(empty), 64'h1);
      chk("rst_full", 64'(full), 64'h0);
      chk("rst_op_ready", 64'(bus.op_ready), 64'h1);
      chk("rst_late_err", 64'(late_err), 64'h0);
      chk("rst_ovf_err", 64'(ovf_err), 64'h0);
   endtask

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_tl = 0;
      m_timer = 0;
      m_late = 0;
      m_ovf = 0;
      m_last_data = '0;
      m_last_ts = '0;
   endtask

   // Scoreboard monitor: every issue pulse must match the next predicted release.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (bus.issue_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL issue_unexpected: got ts %0h data %0h expected no issue (cycle %0d)",
                           bus.issue_ts, bus.issue_data, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("issue_cycle", 64'(cyc), 64'(e.cyc));
                  chk("issue_data", 64'(bus.issue_data), 64'(e.data));
                  chk("issue_ts", 64'(bus.issue_ts), 64'(e.ts));
               end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
               e = exp_q.pop_front();
               n_vec++;
               n_err++;
               $display("FAIL issue_missing: got no issue expected ts %0h data %0h (cycle %0d)",
                        e.ts, e.data, cyc);
            end
         end
      end
   end

   initial begin
      bit rn_r;
      zero_inputs();
      #22;
      check_reset_values();
      @(negedge clk);
      reset_n = 1'b1;

      // Basic timing: A@0, wait 5, B@5, waitr 3, C@8, then run.
      tick(1, 32'hA, 0, 0, 0, 32'h0, 0, 0);
      tick(0, 32'h0, 1, 0, 5, 32'h0, 0, 0);
      tick(1, 32'hB, 0, 0, 0, 32'h0, 0, 0);
      tick(0, 32'h0, 1, 1, 0, 32'h3, 0, 0);
      tick(1, 32'hC, 0, 0, 0, 32'h0, 0, 0);
      idle(12, 1);

      // Same-cycle push and wait: tl 4, then push with wait 10.
      tick(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
      tick(0, 32'h0, 1, 0, 4, 32'h0, 0, 0);
      tick(1, 32'h11, 1, 0, 10, 32'h0, 0, 0);
      tick(1, 32'h12, 0, 0, 0, 32'h0, 0, 0);
      idle(18, 1);

      // Fill to DEPTH, overflow, then drain.
      tick(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
      for (int i = 0; i < DEPTH + 1; i++) tick(1, 32'h100 + 32'(i), 0, 0, 0, 32'h0, 0, 0);
      idle(2, 0);
      idle(12, 1);

      // Late issue: timer beyond the pushed timestamp.
      tick(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
      tick(0, 32'h0, 1, 0, 10, 32'h0, 1, 0);
      idle(19, 1);
      tick(1, 32'h200, 0, 0, 0, 32'h0, 1, 0);
      idle(4, 1);

      // Timeline saturation.
      tick(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
      tick(0, 32'h0, 1, 1, 0, 32'hFFFF_FFF0, 0, 0);
      tick(0, 32'h0, 1, 1, 0, 32'h0000_0020, 0, 0);
      tick(1, 32'h300, 0, 0, 0, 32'h0, 0, 0);
      idle(3, 0);

      // Flush with three queued entries; sticky flags survive.
      tick(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
      for (int i = 0; i < 3; i++) tick(1, 32'h400 + 32'(i), 1, 0, 2, 32'h0, 0, 0);
      tick(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
      idle(3, 0);

      // Refill, start issuing, then reset asynchronously mid-issue.
      for (int i = 0; i < 3; i++) tick(1, 32'h500 + 32'(i), 1, 0, 1, 32'h0, 0, 0);
      tick(0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_values();
      zero_inputs();
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // Random traffic.
      rn_r = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) rn_r = !rn_r;
         tick($urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 6)), 32'($urandom_range(0, 6)), rn_r, $urandom_range(0, 99) == 0);
      end

      idle(4, 0);
      @(negedge clk);
      check_status();
      chk("pending_issues", 64'(exp_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/q_timing_queue.md
Name: q_timing_queue

Overview:
- Timing-point buffer directly downstream of the instruction decoder in the quantum control core.
- Accumulates QWAIT/QWAITR intervals into a running timeline timestamp, and tags each decoded quantum operation (SMSO/SITO/ROT payloads) with that timestamp.
- Buffers tagged ops in a FIFO and releases each to the quantum pulse interface when a free-running run timer reaches its timestamp.

Parameters:
- DATA_W, 32, width of quantum-op payload word.
- IMM_W, 20, width of QWAIT immediate interval.
- TS_W, 32, width of timeline timestamp and run timer.
- DEPTH, 8, FIFO entries (power of two, >=2).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- q_time_write  in  1  decoder strobe: advance timeline this cycle.
- q_time_sel  in  1  interval source: 0 = wait_imm, 1 = wait_reg.
- wait_imm  in  IMM_W  QWAIT immediate interval (cycles), zero-extended.
- wait_reg  in  TS_W  QWAITR register interval (cycles).
- op_valid  in  1  decoded quantum op present.
- op_data  in  DATA_W  quantum op payload.
- op_ready  out  1  FIFO can accept; equals !full.
- run  in  1  timer enable; 0 holds timer at 0 and blocks issue.
- flush  in  1  synchronous clear of FIFO, timeline and timer.
- issue_valid  out  1  one-cycle pulse: op released.
- issue_data  out  DATA_W  released payload.
- issue_ts  out  TS_W  timestamp of released op.
- timer  out  TS_W  current run timer.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- late_err  out  1  sticky: an op was issued after its timestamp.
- ovf_err  out  1  sticky: push while full, or timeline saturated.

Behaviour:
- Reset: all outputs 0 except empty=1 and op_ready=1. Internal tl_ts=0, FIFO pointers=0. Reset is asynchronous and may assert mid-operation; all in-flight entries are discarded.
- Timeline:
  - On an edge with q_time_write=1: tl_ts <= tl_ts + interval, where interval is the selected source (immediate zero-extended).
  - Addition is unsigned and saturates at 2^TS_W-1. Saturation sets ovf_err.
  - Interval 0 leaves tl_ts unchanged.
- Push:
  - On an edge with op_valid && !full, write {op_data, tl_ts} at the write pointer.
  - If q_time_write is also high in the same cycle, the op takes the pre-advance tl_ts.
  - op_valid while full: op dropped, ovf_err set, pointers unchanged.
- Timer:
  - run=0: timer <= 0.
  - run=1: timer <= timer + 1, wrapping modulo 2^TS_W with no flag.
- Issue (registered):
  - Condition at each edge: run && !empty && head_ts <= timer (unsigned, using pre-increment timer).
  - If true: pop head, issue_valid <= 1, issue_data/issue_ts <= head fields. If head_ts < timer, also set late_err.
  - Else issue_valid <= 0; issue_data/issue_ts hold their last values.
  - Maximum one issue per cycle. Entries with equal timestamps issue on consecutive cycles; the second and later are late.
- Simultaneous push and pop:
  - Allowed at any occupancy below DEPTH; count unchanged.
  - When full, push is rejected before the pop is considered (op_ready=0 that cycle).
  - A push into an empty FIFO is not issuable until the following edge (1-cycle minimum latency from push to issue_valid).
- flush:
  - Synchronous, highest priority over push, pop and timeline.
  - Clears FIFO, tl_ts and timer, and forces issue_valid to 0.
  - late_err and ovf_err are cleared only by reset_n.
- Flag timing: full/empty/op_ready are derived from the registered count and are valid in the same cycle.

Optional Feature:
- Macro Q_LATE_DROP_EN.
- Defined: a head entry with head_ts < timer at the issue edge is popped without issue; issue_valid stays 0 and late_err is set. The next entry is evaluated at the following edge. An entry with head_ts == timer issues normally.
- Undefined: late entries issue as described in Behaviour, with late_err set.

Test Plan:
- Basic timing: run=0; push op A (ts 0); QWAIT 5; push B; QWAITR wait_reg=3; push C; assert run -> A issues with issue_ts=0, B with issue_ts=5, C with issue_ts=8. Each issue_valid pulses on the edge where timer equals its ts; late_err=0.
- Same-cycle push and wait: q_time_write=1 (imm 10) and op_valid=1 with tl_ts=4 -> entry ts=4, tl_ts becomes 14.
- Full/overflow, DEPTH=8, run=0: 8 pushes -> full=1, op_ready=0. 9th op_valid -> dropped and ovf_err=1. run=1 -> exactly 8 issue pulses, then empty=1.
- Late issue: run=1 and timer already 20; push op with tl_ts=10 -> issues next edge with issue_ts=10 and late_err=1. With Q_LATE_DROP_EN: no issue_valid, late_err=1, empty=1.
- Saturation: tl_ts=0xFFFF_FFF0, QWAITR wait_reg=0x20 -> tl_ts=0xFFFF_FFFF, ovf_err=1.
- Flush and reset: 3 entries queued, pulse flush -> empty=1, tl_ts=0, timer=0, sticky flags kept. Refill, then assert reset_n=0 mid-issue -> outputs at reset values immediately, late_err=ovf_err=0.
